uart_tx_driver: RTL and testbench

- Synthesizable UART transmitter that drives the SoC's `io_uart_rx` pin from the testbench side.
- It is the sending counterpart of the receive-side tty monitor, which only watches the SoC's `io_uart_tx` pin.
- Bytes are pushed in through a valid/ready port, buffered in a small FIFO, and serialized as 8N1 (or 8N2) frames, LSB first, at a fixed clocks-per-bit rate.
- Testcases use it to feed console input to firmware running on the core.

---
 rtl/uart_tx_driver.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_driver.sv
// uart_tx_driver
//   Byte-oriented UART transmitter that drives the SoC io_uart_rx pin so that
//   testcases can feed console input to firmware. Bytes enter through a
//   valid/ready port, sit in a small FIFO, and leave as 8N1/8N2 frames,
//   LSB first, at CLKS_PER_BIT clocks per bit.
//
// Ports
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   tx_en       : allows a new frame to start (never truncates a frame)
//   in_valid    : producer presents in_data
//   in_ready    : FIFO has room (from registered count, no bypass)
//   in_data     : byte to transmit
//   tx          : serial line, idle high, driven from a flop
//   busy        : a frame is in progress
//   fifo_count  : bytes queued, excluding the byte being shifted
//
// State   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte with tx_en set
// S_START | start bit, line low for one bit period
// S_DATA  | data bits 0..7, line = shift_q[0]
// S_STOP  | STOP_BITS bit periods high, then chain or return to idle
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       tx_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_en_q;
  logic [7:0]        mem_q [DEPTH];

  logic push;
  logic pop;
  logic tick;
  logic fifo_nempty;

  // ready_en_q keeps in_ready low while reset is held, even though the
  // count alone would already report room.
  assign fifo_nempty = (count_q != '0);
  assign in_ready    = ready_en_q && (count_q < DEPTH_C);
  assign push        = in_valid && in_ready;
  assign tick        = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = tick ? '0 : baud_q + 1'b1;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_nempty && tx_en) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        // bit_idx_q counts stop-bit periods here.
        if (tick) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (fifo_nempty && tx_en) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so the pad flop changes on
    // the same edge as the state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
module tb_uart_tx_driver;

  logic       clock = 1'b0;
  logic       reset_n;

  logic       tx_en1, in_valid1, in_ready1, tx1, busy1;
  logic [7:0] in_data1;
  logic [3:0] cnt1;

  logic       tx_en2, in_valid2, in_ready2, tx2, busy2;
  logic [7:0] in_data2;
  logic [3:0] cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_driver #(.CLKS_PER_BIT(4), .DEPTH(8), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .tx_en(tx_en1), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_data(in_data1), .tx(tx1), .busy(busy1),
    .fifo_count(cnt1));

  uart_tx_driver #(.CLKS_PER_BIT(4), .DEPTH(8), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .tx_en(tx_en2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_data(in_data2), .tx(tx2), .busy(busy2),
    .fifo_count(cnt2));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that starts a frame. Checks tx and busy on
  // every cycle of the frame and returns one frame length later.
  task automatic check_frame(input string tag, input logic [7:0] b,
                             input int sb, input bit sel, input int drop_at);
    int   len;
    logic exp_tx;
    len = (9 + sb) * 4;
    for (int off = 0; off < len; off++) begin
      if (off < 4)       exp_tx = 1'b0;
      else if (off < 36) exp_tx = b[(off - 4) / 4];
      else               exp_tx = 1'b1;
      chk($sformatf("%s tx@%0d", tag, off), sel ? tx2 : tx1, exp_tx);
      chk($sformatf("%s busy@%0d", tag, off), sel ? busy2 : busy1, 1'b1);
      if (off == drop_at) tx_en1 = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_en1    = 1'b1; in_valid1 = 1'b0; in_data1 = 8'h00;
    tx_en2    = 1'b1; in_valid2 = 1'b0; in_data2 = 8'h00;
    #12;
    chk("rst tx", tx1, 1'b1);
    chk("rst busy", busy1, 1'b0);
    chk("rst ready", in_ready1, 1'b0);
    chk("rst count", cnt1, 4'd0);
    tick(1);
    reset_n = 1'b1;
    chk("rel ready pre-edge", in_ready1, 1'b0);
    tick(1);
    chk("rel ready", in_ready1, 1'b1);
    tick(3);

    // Single byte 0x55
    in_valid1 = 1'b1; in_data1 = 8'h55;
    tick(1);
    in_valid1 = 1'b0;
    chk("t1 tx at push", tx1, 1'b1);
    chk("t1 count at push", cnt1, 4'd1);
    tick(1);
    chk("t1 count after pop", cnt1, 4'd0);
    check_frame("t1", 8'h55, 1, 1'b0, -1);
    chk("t1 busy end", busy1, 1'b0);
    chk("t1 tx end", tx1, 1'b1);
    tick(3);

    // Back-to-back 0xA3, 0x0F
    in_valid1 = 1'b1; in_data1 = 8'hA3;
    tick(1);
    chk("t2 count 1st", cnt1, 4'd1);
    in_data1 = 8'h0F;
    tick(1);
    in_valid1 = 1'b0;
    chk("t2 count push+pop", cnt1, 4'd1);
    check_frame("t2a", 8'hA3, 1, 1'b0, -1);
    chk("t2 count 2nd pop", cnt1, 4'd0);
    check_frame("t2b", 8'h0F, 1, 1'b0, -1);
    chk("t2 busy end", busy1, 1'b0);
    tick(3);

    // Full FIFO with transmit disabled
    tx_en1 = 1'b0;
    in_valid1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data1 = 8'(i);
      chk($sformatf("t3 ready %0d", i), in_ready1, (i < 8) ? 1'b1 : 1'b0);
      tick(1);
    end
    in_valid1 = 1'b0;
    chk("t3 count full", cnt1, 4'd8);
    chk("t3 ready full", in_ready1, 1'b0);
    chk("t3 idle tx", tx1, 1'b1);
    chk("t3 idle busy", busy1, 1'b0);
    tx_en1 = 1'b1;
    tick(1);
    chk("t3 count first pop", cnt1, 4'd7);
    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("t3f%0d", i), 8'(i), 1, 1'b0, -1);
    end
    chk("t3 busy end", busy1, 1'b0);
    chk("t3 count end", cnt1, 4'd0);
    tick(3);

    // Enable gating: drop tx_en in DATA of the first frame
    in_valid1 = 1'b1; in_data1 = 8'h3C;
    tick(1);
    in_data1 = 8'hC5;
    tick(1);
    in_valid1 = 1'b0;
    check_frame("t4a", 8'h3C, 1, 1'b0, 14);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4 held tx %0d", i), tx1, 1'b1);
      chk($sformatf("t4 held busy %0d", i), busy1, 1'b0);
      chk($sformatf("t4 held count %0d", i), cnt1, 4'd1);
      tick(1);
    end
    tx_en1 = 1'b1;
    chk("t4 no start before edge", tx1, 1'b1);
    tick(1);
    check_frame("t4b", 8'hC5, 1, 1'b0, -1);
    chk("t4 busy end", busy1, 1'b0);
    tick(3);

    // Reset during bit 3 of 0x96 with another byte queued
    in_valid1 = 1'b1; in_data1 = 8'h96;
    tick(1);
    in_data1 = 8'h11;
    tick(1);
    in_valid1 = 1'b0;
    tick(18);
    chk("t5 bit3 low", tx1, 1'b0);
    chk("t5 count queued", cnt1, 4'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5 async tx", tx1, 1'b1);
    chk("t5 async busy", busy1, 1'b0);
    chk("t5 async count", cnt1, 4'd0);
    chk("t5 async ready", in_ready1, 1'b0);
    tick(2);
    chk("t5 held tx", tx1, 1'b1);
    reset_n = 1'b1;
    tick(1);
    chk("t5 ready after rel", in_ready1, 1'b1);
    chk("t5 idle after rel", busy1, 1'b0);
    in_valid1 = 1'b1; in_data1 = 8'hFF;
    tick(1);
    in_valid1 = 1'b0;
    tick(1);
    check_frame("t5", 8'hFF, 1, 1'b0, -1);
    chk("t5 busy end", busy1, 1'b0);
    chk("t5 count end", cnt1, 4'd0);

    // Two stop bits: 0x00 twice, 44-cycle period
    in_valid2 = 1'b1; in_data2 = 8'h00;
    tick(1);
    tick(1);
    in_valid2 = 1'b0;
    chk("t6 count", cnt2, 4'd1);
    check_frame("t6a", 8'h00, 2, 1'b1, -1);
    chk("t6 count 2nd pop", cnt2, 4'd0);
    check_frame("t6b", 8'h00, 2, 1'b1, -1);
    chk("t6 busy end", busy2, 1'b0);
    chk("t6 tx end", tx2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
